// File: rtl/tile_map_renderer_pkg.sv
// Shared video constants for the tile map reader: map geometry, index widths and
// the fixed pixel pipeline depth.
package tile_map_renderer_pkg;

  localparam int MAP_W      = 80;
  localparam int MAP_H      = 50;
  localparam int TILE_BITS  = 6;
  localparam int ADDR_BITS  = 12;
  localparam int LATENCY    = 3;
  localparam int COLOR_BITS = 4;

endpackage

// File: rtl/tile_map_renderer_tile_addr_gen.sv
// Tile map address for one pixel: coarse scroll add, single-subtract wrap onto the
// 80x50 map, then row*80+col via shift-add.
module tile_addr_gen
  import tile_map_renderer_pkg::*;
(
  input  logic [6:0]           tile_col,
  input  logic [6:0]           tile_row,
  input  logic [6:0]           scroll_col,
  input  logic [5:0]           scroll_row,
  output logic [ADDR_BITS-1:0] addr
);

  logic [7:0]  col_sum;
  logic [7:0]  row_sum;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [13:0] lin;

  always_comb begin
    col_sum = {1'b0, tile_col} + {1'b0, scroll_col};
    row_sum = {1'b0, tile_row} + {2'b00, scroll_row};
    col     = (col_sum >= 8'(MAP_W)) ? col_sum - 8'(MAP_W) : col_sum;
    row     = (row_sum >= 8'(MAP_H)) ? row_sum - 8'(MAP_H) : row_sum;
    // row*80 = row*64 + row*16
    lin     = {row, 6'b0} + {2'b00, row, 4'b0} + {6'b0, col};
    addr    = lin[ADDR_BITS-1:0];
  end

endmodule

// File: rtl/tile_map_renderer.sv
// Tile map reader: address, pattern fetch and pixel select in a 3-stage pipeline,
// with syncs and blank delayed to line up with pix_color.
module tile_map_renderer
  import tile_map_renderer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  active,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [6:0]            scroll_col,
  input  logic [5:0]            scroll_row,
  input  logic [COLOR_BITS-1:0] fg_color,
  input  logic [COLOR_BITS-1:0] bg_color,
  output logic [ADDR_BITS-1:0]  tile_raddr,
  output logic                  tile_ren,
  input  logic [TILE_BITS-1:0]  tile_rdata,
  output logic [TILE_BITS+2:0]  pat_raddr,
  output logic                  pat_ren,
  input  logic [7:0]            pat_rdata,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out
);

  logic [ADDR_BITS-1:0]  map_addr;
  logic [2:0]            px_d1, px_d2;
  logic [2:0]            py_d1;
  logic                  act_d1, act_d2;
  logic [COLOR_BITS-1:0] fg_d1, fg_d2, bg_d1, bg_d2;
  logic [LATENCY-1:0]    hs_sr, vs_sr, bl_sr;
  logic                  pat_bit;

  tile_addr_gen u_addr_gen (
    .tile_col   (x[9:3]),
    .tile_row   (y[9:3]),
    .scroll_col (scroll_col),
    .scroll_row (scroll_row),
    .addr       (map_addr)
  );

  // Colours travel with the pixel so a change applies from the next pixel entering S0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_raddr <= '0;
      tile_ren   <= 1'b0;
      px_d1      <= '0;
      py_d1      <= '0;
      act_d1     <= 1'b0;
      fg_d1      <= '0;
      bg_d1      <= '0;
      pat_raddr  <= '0;
      pat_ren    <= 1'b0;
      px_d2      <= '0;
      act_d2     <= 1'b0;
      fg_d2      <= '0;
      bg_d2      <= '0;
      pix_color  <= '0;
      hs_sr      <= '0;
      vs_sr      <= '0;
      bl_sr      <= '0;
    end else begin
      tile_raddr <= map_addr;
      tile_ren   <= active;
      px_d1      <= x[2:0];
      py_d1      <= y[2:0];
      act_d1     <= active;
      fg_d1      <= fg_color;
      bg_d1      <= bg_color;

      pat_raddr  <= {tile_rdata, py_d1};
      pat_ren    <= act_d1;
      px_d2      <= px_d1;
      act_d2     <= act_d1;
      fg_d2      <= fg_d1;
      bg_d2      <= bg_d1;

      pix_color  <= act_d2 ? (pat_bit ? fg_d2 : bg_d2) : '0;

      hs_sr      <= {hs_sr[LATENCY-2:0], hsync_in};
      vs_sr      <= {vs_sr[LATENCY-2:0], vsync_in};
      bl_sr      <= {bl_sr[LATENCY-2:0], ~active};
    end
  end

  always_comb begin
    pat_bit = pat_rdata[3'd7 - px_d2];
  end

  assign hsync_out = hs_sr[LATENCY-1];
  assign vsync_out = vs_sr[LATENCY-1];
  assign blank_out = bl_sr[LATENCY-1];

endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed and random checks of the tile map reader against a per-pixel arithmetic
// model; map RAM and pattern ROM are modelled as arrays read from the registered addresses.
module tb_tile_map_renderer;

  logic        clk;
  logic        reset;
  logic [9:0]  x, y;
  logic        active, hsync_in, vsync_in;
  logic [6:0]  scroll_col;
  logic [5:0]  scroll_row;
  logic [3:0]  fg_color, bg_color;
  logic [11:0] tile_raddr;
  logic        tile_ren;
  logic [5:0]  tile_rdata;
  logic [8:0]  pat_raddr;
  logic        pat_ren;
  logic [7:0]  pat_rdata;
  logic [3:0]  pix_color;
  logic        hsync_out, vsync_out, blank_out;

  tile_map_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .active     (active),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .scroll_col (scroll_col),
    .scroll_row (scroll_row),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .tile_raddr (tile_raddr),
    .tile_ren   (tile_ren),
    .tile_rdata (tile_rdata),
    .pat_raddr  (pat_raddr),
    .pat_ren    (pat_ren),
    .pat_rdata  (pat_rdata),
    .pix_color  (pix_color),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] map_mem [0:3999];
  logic [7:0] rom     [0:511];

  assign tile_rdata = (tile_raddr < 12'd4000) ? map_mem[tile_raddr] : 6'd0;
  assign pat_rdata  = rom[pat_raddr];

  typedef struct {
    bit valid;
    bit act;
    int addr;
    int paddr;
    int color;
    bit hs;
    bit vs;
  } ent_t;

  ent_t cur, h0, h1, h2;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected behaviour of one pixel, straight from the map/pattern rules.
  function automatic ent_t model(int xx, int yy, bit act, bit hs, bit vs);
    ent_t e;
    int col, row, tile, pat, b;
    col     = (xx / 8 + int'(scroll_col)) % 80;
    row     = (yy / 8 + int'(scroll_row)) % 50;
    e.valid = 1'b1;
    e.act   = act;
    e.addr  = row * 80 + col;
    tile    = int'(map_mem[e.addr]);
    e.paddr = tile * 8 + (yy % 8);
    pat     = int'(rom[e.paddr]);
    b       = (pat >> (7 - (xx % 8))) & 1;
    e.color = act ? ((b != 0) ? int'(fg_color) : int'(bg_color)) : 0;
    e.hs    = hs;
    e.vs    = vs;
    return e;
  endfunction

  task automatic drive(input int xx, input int yy, input bit act, input bit hs, input bit vs);
    x        = 10'(xx);
    y        = 10'(yy);
    active   = act;
    hsync_in = hs;
    vsync_in = vs;
    cur      = model(xx, yy, act, hs, vs);
    cur.valid = !reset;
  endtask

  task automatic tick();
    logic rst_s;
    rst_s = reset;
    @(posedge clk);
    #1;
    cyc++;
    h2 = h1;
    h1 = h0;
    h0 = cur;
    if (rst_s) begin
      h0.valid = 1'b0;
      h1.valid = 1'b0;
      h2.valid = 1'b0;
      check("rst_tile_raddr", 32'(tile_raddr), 32'd0);
      check("rst_tile_ren",   32'(tile_ren),   32'd0);
      check("rst_pat_raddr",  32'(pat_raddr),  32'd0);
      check("rst_pat_ren",    32'(pat_ren),    32'd0);
      check("rst_pix_color",  32'(pix_color),  32'd0);
      check("rst_hsync_out",  32'(hsync_out),  32'd0);
      check("rst_vsync_out",  32'(vsync_out),  32'd0);
      check("rst_blank_out",  32'(blank_out),  32'd0);
    end else begin
      if (h0.valid) begin
        check("tile_ren", 32'(tile_ren), 32'(h0.act));
        if (h0.act) check("tile_raddr", 32'(tile_raddr), 32'(h0.addr));
      end
      if (h1.valid) begin
        check("pat_ren", 32'(pat_ren), 32'(h1.act));
        if (h1.act) check("pat_raddr", 32'(pat_raddr), 32'(h1.paddr));
      end
      if (h2.valid) begin
        check("pix_color", 32'(pix_color), 32'(h2.color));
        check("hsync_out", 32'(hsync_out), 32'(h2.hs));
        check("vsync_out", 32'(vsync_out), 32'(h2.vs));
        check("blank_out", 32'(blank_out), 32'(!h2.act));
      end
    end
  endtask

  logic [3:0] exp_row [0:7];

  initial begin
    h0.valid = 1'b0;
    h1.valid = 1'b0;
    h2.valid = 1'b0;
    for (int i = 0; i < 4000; i++) map_mem[i] = 6'($urandom);
    for (int i = 0; i < 512; i++)  rom[i]     = 8'($urandom);
    map_mem[165] = 6'h2A;
    map_mem[240] = 6'h11;
    rom[9'h088]  = 8'b1000_0001;

    reset      = 1'b1;
    scroll_col = '0;
    scroll_row = '0;
    fg_color   = 4'h7;
    bg_color   = 4'h2;
    drive(40, 16, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with active high, then first pixel latency.
    tick();
    tick();
    reset = 1'b0;
    drive(40, 16, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        check("latency_pix_early",   32'(pix_color), 32'd0);
        check("latency_blank_early", 32'(blank_out), 32'd0);
      end
    end

    // Addressing and pattern fetch.
    drive(40, 16, 1'b1, 1'b0, 1'b0);
    tick();
    check("addr_165",     32'(tile_raddr), 32'd165);
    check("addr_ren",     32'(tile_ren),   32'd1);
    drive(40, 19, 1'b1, 1'b0, 1'b0);
    tick();
    drive(40, 16, 1'b1, 1'b0, 1'b0);
    tick();
    check("pat_raddr_153", 32'(pat_raddr), 32'h153);
    check("pat_ren_1",     32'(pat_ren),   32'd1);

    // Pixel select across one pattern row.
    fg_color = 4'hF;
    bg_color = 4'h1;
    exp_row  = '{4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF};
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(i, 24, 1'b1, 1'b0, 1'b0);
      else       drive(0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 2) check("pix_sel", 32'(pix_color), 32'(exp_row[i-2]));
    end

    // Wrap on both axes.
    scroll_col = 7'd79;
    scroll_row = 6'd49;
    drive(8, 8, 1'b1, 1'b0, 1'b0);
    tick();
    check("wrap_addr_0", 32'(tile_raddr), 32'd0);
    drive(0, 8, 1'b1, 1'b0, 1'b0);
    tick();
    check("wrap_addr_79", 32'(tile_raddr), 32'd79);
    tick();
    tick();

    // Blanking with an hsync pulse.
    for (int i = 0; i < 6; i++) begin
      drive(700, 8, 1'b0, (i == 0), 1'b0);
      tick();
      check("blank_tile_ren", 32'(tile_ren), 32'd0);
      if (i >= 1) check("blank_pat_ren", 32'(pat_ren), 32'd0);
      if (i >= 2) begin
        check("blank_hsync", 32'(hsync_out), 32'(i == 2));
        check("blank_pix",   32'(pix_color), 32'd0);
        check("blank_flag",  32'(blank_out), 32'd1);
      end
    end

    // Random pixels, scroll and colours, with a reset in the middle.
    for (int k = 0; k < 800; k++) begin
      bit a;
      if (k == 400) begin
        reset = 1'b1;
        drive(100, 100, 1'b1, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
      end
      a          = ($urandom_range(0, 7) != 0);
      scroll_col = 7'($urandom_range(0, 79));
      scroll_row = 6'($urandom_range(0, 49));
      fg_color   = 4'($urandom);
      bg_color   = 4'($urandom);
      drive(a ? $urandom_range(0, 639) : $urandom_range(0, 1023),
            a ? $urandom_range(0, 399) : $urandom_range(0, 1023),
            a, 1'($urandom), 1'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
